// File: rtl/pi1_to_wb4_pipe.sv
// pi1_to_wb4_pipe
// Single-clock bridge from a PI1 slave port to a Wishbone B4 pipelined master.
// Writes are posted into a small FIFO so the PI1 master is released at once.
// Reads and swaps (RW) wait until every buffered write has completed on the
// bus. Bus errors and slave timeouts set a sticky error flag.
//
// Ports:
//   wb4_clk_i, wb4_rst_n_i        clock, asynchronous active-low reset
//   pi1_op_i/addr_i/data_i/sel_i  PI1 request (00 NOOP, 01 WR, 10 RD, 11 RW)
//   pi1_data_o, pi1_rdy_o         PI1 read data and ready
//   wb4_cyc_o/stb_o/we_o/addr_o/data_o/sel_o   WB4 master request
//   wb4_stall_i/ack_i/err_i/data_i             WB4 slave response
//   err_o, err_clr_i              sticky error flag and its clear
//   wrbuf_lvl_o                   posted-write buffer occupancy
module pi1_to_wb4_pipe #(
    parameter int ARCHBITSZ  = 32,
    parameter int WRBUFDEPTH = 4,
    parameter int TIMEOUT    = 256,
    localparam int SELW      = ARCHBITSZ / 8,
    localparam int IDXW      = $clog2(SELW),
    localparam int ADDRBITSZ = ARCHBITSZ - IDXW,
    localparam int LVLW      = $clog2(WRBUFDEPTH) + 1
) (
    input  logic                 wb4_clk_i,
    input  logic                 wb4_rst_n_i,
    input  logic [1:0]           pi1_op_i,
    input  logic [ADDRBITSZ-1:0] pi1_addr_i,
    input  logic [ARCHBITSZ-1:0] pi1_data_i,
    output logic [ARCHBITSZ-1:0] pi1_data_o,
    input  logic [SELW-1:0]      pi1_sel_i,
    output logic                 pi1_rdy_o,
    output logic                 wb4_cyc_o,
    output logic                 wb4_stb_o,
    output logic                 wb4_we_o,
    output logic [ARCHBITSZ-1:0] wb4_addr_o,
    output logic [ARCHBITSZ-1:0] wb4_data_o,
    output logic [SELW-1:0]      wb4_sel_o,
    input  logic                 wb4_stall_i,
    input  logic                 wb4_ack_i,
    input  logic                 wb4_err_i,
    input  logic [ARCHBITSZ-1:0] wb4_data_i,
    output logic                 err_o,
    input  logic                 err_clr_i,
    output logic [LVLW-1:0]      wrbuf_lvl_o
);

    localparam int BIDXW = $clog2(WRBUFDEPTH);
    localparam int TMRW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMRW-1:0] TMO_VAL  = TMRW'(TIMEOUT);
    localparam logic [LVLW-1:0] FULL_LVL = LVLW'(WRBUFDEPTH);

    localparam logic [1:0] OP_NOOP = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RW   = 2'b11;

    typedef enum logic [1:0] {IDLE, RDWAIT, RDBUS, RWWR} state_t;

    state_t state, state_nx;

    // Lowest set byte-select bit gives the byte offset; sel=0 maps to 0.
    function automatic logic [IDXW-1:0] low_idx(input logic [SELW-1:0] s);
        low_idx = '0;
        for (int i = SELW - 1; i >= 0; i--) begin
            if (s[i]) low_idx = IDXW'(i);
        end
    endfunction

    // ------------------------------------------------------------------
    // Posted-write FIFO. Pointers carry one extra wrap bit so that the
    // difference is the occupancy directly.
    // ------------------------------------------------------------------
    logic [ADDRBITSZ-1:0] fb_addr [WRBUFDEPTH];
    logic [ARCHBITSZ-1:0] fb_data [WRBUFDEPTH];
    logic [SELW-1:0]      fb_sel  [WRBUFDEPTH];
    logic [LVLW-1:0]      wr_ptr, rd_ptr;

    // Captured RD/RW request
    logic [ADDRBITSZ-1:0] rq_addr;
    logic [ARCHBITSZ-1:0] rq_data;
    logic [SELW-1:0]      rq_sel;
    logic                 rq_rw;

    // WB engine state
    logic                 cyc, stb, we;
    logic [ARCHBITSZ-1:0] addr_q, wdat_q;
    logic [SELW-1:0]      sel_q;
    logic [TMRW-1:0]      tmr;
    logic [ARCHBITSZ-1:0] rw_q;      // read half of a swap, held across the write half
    logic [ARCHBITSZ-1:0] rdat_q;
    logic                 err_q;

    logic                 accept, push, pop;
    logic                 tmo_hit, term, term_err;
    logic                 buf_owner, rd_go, wr_go;
    logic                 buf_empty;
    logic [ADDRBITSZ-1:0] ld_addr;
    logic [SELW-1:0]      ld_sel;
    logic [BIDXW-1:0]     head;

    assign wrbuf_lvl_o = wr_ptr - rd_ptr;
    assign buf_empty   = (wrbuf_lvl_o == '0);
    assign head        = rd_ptr[BIDXW-1:0];

    assign accept = pi1_rdy_o && (pi1_op_i != OP_NOOP);
    assign push   = accept && (pi1_op_i == OP_WR);

    // ack beats timeout on the same cycle; err beats ack.
    assign tmo_hit  = (TIMEOUT != 0) && (tmr == TMO_VAL);
    assign term     = cyc && (wb4_ack_i || wb4_err_i || tmo_hit);
    assign term_err = cyc && (wb4_err_i || (tmo_hit && !wb4_ack_i));

    // The buffer owns the bus whenever the FSM is not running a read/swap.
    assign buf_owner = (state != RDBUS) && (state != RWWR);
    assign pop       = term && buf_owner;

    // A read is launched on the accept edge itself when the path is already
    // clear, so a zero-wait slave costs only one not-ready cycle; otherwise
    // it launches on leaving RDWAIT.
    assign rd_go = !cyc && buf_empty &&
                   (((state == IDLE) && accept && pi1_op_i[1]) || (state == RDWAIT));
    assign wr_go = !cyc && !buf_empty && buf_owner;

    assign ld_addr = (state == IDLE) ? pi1_addr_i : rq_addr;
    assign ld_sel  = (state == IDLE) ? pi1_sel_i  : rq_sel;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge wb4_clk_i or negedge wb4_rst_n_i) begin
        if (!wb4_rst_n_i) state <= IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (accept && pi1_op_i[1]) state_nx = rd_go ? RDBUS : RDWAIT;
            RDWAIT: if (rd_go) state_nx = RDBUS;
            RDBUS:  if (term) state_nx = (rq_rw && !term_err) ? RWWR : IDLE;
            RWWR:   if (term) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pi1_rdy_o = wb4_rst_n_i && (state == IDLE) && (wrbuf_lvl_o != FULL_LVL);
    end

    // ------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------
    always_ff @(posedge wb4_clk_i) begin
        if (push) begin
            fb_addr[wr_ptr[BIDXW-1:0]] <= pi1_addr_i;
            fb_data[wr_ptr[BIDXW-1:0]] <= pi1_data_i;
            fb_sel[wr_ptr[BIDXW-1:0]]  <= pi1_sel_i;
        end
    end

    always_ff @(posedge wb4_clk_i or negedge wb4_rst_n_i) begin
        if (!wb4_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LVLW'(1);
            if (pop)  rd_ptr <= rd_ptr + LVLW'(1);
        end
    end

    // ------------------------------------------------------------------
    // RD/RW request capture
    // ------------------------------------------------------------------
    always_ff @(posedge wb4_clk_i or negedge wb4_rst_n_i) begin
        if (!wb4_rst_n_i) begin
            rq_addr <= '0;
            rq_data <= '0;
            rq_sel  <= '0;
            rq_rw   <= 1'b0;
        end else if (accept && pi1_op_i[1]) begin
            rq_addr <= pi1_addr_i;
            rq_data <= pi1_data_i;
            rq_sel  <= pi1_sel_i;
            rq_rw   <= (pi1_op_i == OP_RW);
        end
    end

    // ------------------------------------------------------------------
    // WB engine: one outstanding transaction
    // ------------------------------------------------------------------
    always_ff @(posedge wb4_clk_i or negedge wb4_rst_n_i) begin
        if (!wb4_rst_n_i) begin
            cyc    <= 1'b0;
            stb    <= 1'b0;
            we     <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
            sel_q  <= '0;
            tmr    <= '0;
            rw_q   <= '0;
            rdat_q <= '0;
        end else begin
            if (stb && !wb4_stall_i) stb <= 1'b0;
            if (cyc && (TIMEOUT != 0)) tmr <= tmr + TMRW'(1);

            if (term) begin
                if ((state == RDBUS) && rq_rw && !term_err) begin
                    // Swap: keep the cycle open and turn it into the write half.
                    stb    <= 1'b1;
                    we     <= 1'b1;
                    wdat_q <= rq_data;
                    sel_q  <= rq_sel;
                    tmr    <= TMRW'(1);
                    rw_q   <= wb4_data_i;
                end else begin
                    cyc <= 1'b0;
                    stb <= 1'b0;
                    we  <= 1'b0;
                end
                if ((state == RDBUS) && (term_err || !rq_rw))
                    rdat_q <= term_err ? '1 : wb4_data_i;
                if (state == RWWR)
                    rdat_q <= term_err ? '1 : rw_q;
            end else if (rd_go) begin
                cyc    <= 1'b1;
                stb    <= 1'b1;
                we     <= 1'b0;
                addr_q <= {ld_addr, low_idx(ld_sel)};
                wdat_q <= '0;
                sel_q  <= ld_sel;
                tmr    <= TMRW'(1);
            end else if (wr_go) begin
                cyc    <= 1'b1;
                stb    <= 1'b1;
                we     <= 1'b1;
                addr_q <= {fb_addr[head], low_idx(fb_sel[head])};
                wdat_q <= fb_data[head];
                sel_q  <= fb_sel[head];
                tmr    <= TMRW'(1);
            end
        end
    end

    // Sticky error: a new error wins over a simultaneous clear.
    always_ff @(posedge wb4_clk_i or negedge wb4_rst_n_i) begin
        if (!wb4_rst_n_i)   err_q <= 1'b0;
        else if (term_err)  err_q <= 1'b1;
        else if (err_clr_i) err_q <= 1'b0;
    end

    assign wb4_cyc_o  = cyc;
    assign wb4_stb_o  = stb;
    assign wb4_we_o   = we;
    assign wb4_addr_o = addr_q;
    assign wb4_data_o = wdat_q;
    assign wb4_sel_o  = sel_q;
    assign pi1_data_o = rdat_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_pi1_to_wb4_pipe.sv
// Testbench for pi1_to_wb4_pipe: PI1 op driver, WB4 memory slave with
// configurable latency/stall/no-ack/error/zero-wait behaviour, and a
// scoreboard of expected bus transactions checked as the DUT issues them.
module tb_pi1_to_wb4_pipe;

    localparam logic [1:0] OP_NOOP = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_RW   = 2'b11;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  op = OP_NOOP;
    logic [29:0] paddr = '0;
    logic [31:0] pdata = '0;
    logic [31:0] rdata;
    logic [3:0]  psel = '0;
    logic        rdy;
    logic        cyc, stb, we;
    logic [31:0] waddr, wdata, wrdata;
    logic [3:0]  wsel;
    logic        stall, ack, err;
    logic        err_o;
    logic        err_clr = 1'b0;
    logic [2:0]  lvl;

    int checks = 0;
    int fails = 0;
    txn_t exp_q[$];

    always #5 clk = ~clk;

    pi1_to_wb4_pipe #(.ARCHBITSZ(32), .WRBUFDEPTH(4), .TIMEOUT(16)) dut (
        .wb4_clk_i(clk), .wb4_rst_n_i(rst_n),
        .pi1_op_i(op), .pi1_addr_i(paddr), .pi1_data_i(pdata), .pi1_data_o(rdata),
        .pi1_sel_i(psel), .pi1_rdy_o(rdy),
        .wb4_cyc_o(cyc), .wb4_stb_o(stb), .wb4_we_o(we), .wb4_addr_o(waddr),
        .wb4_data_o(wdata), .wb4_sel_o(wsel),
        .wb4_stall_i(stall), .wb4_ack_i(ack), .wb4_err_i(err), .wb4_data_i(wrdata),
        .err_o(err_o), .err_clr_i(err_clr), .wrbuf_lvl_o(lvl)
    );

    // ---------------- WB4 slave model ----------------
    logic [31:0] mem [0:63];
    int  lat = 1;
    bit  no_ack = 0, err_mode = 0, zw = 0;
    int  cyc_cnt = 0;
    int  stall_end = 0;
    logic        ack_r, err_r, pend, pend_err;
    logic [31:0] rdat_r;
    int          cnt;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    assign stall  = (cyc_cnt < stall_end);
    assign ack    = zw ? (cyc && stb) : ack_r;
    assign err    = err_r;
    assign wrdata = zw ? mem[waddr[7:2]] : rdat_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0; err_r <= 1'b0; pend <= 1'b0; pend_err <= 1'b0;
            cnt <= 0; rdat_r <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    ack_r <= !pend_err; err_r <= pend_err; pend <= 1'b0;
                end else cnt <= cnt - 1;
            end
            if (cyc && stb && !stall) begin
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (wsel[b]) mem[waddr[7:2]][8*b +: 8] <= wdata[8*b +: 8];
                end else rdat_r <= mem[waddr[7:2]];
                if (!zw && !no_ack) begin
                    if (lat <= 1) begin
                        ack_r <= !err_mode; err_r <= err_mode;
                    end else begin
                        pend <= 1'b1; cnt <= lat - 1; pend_err <= err_mode;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    // Advance to the next falling edge and check any transaction the slave
    // accepts on the coming rising edge against the scoreboard.
    task automatic tick();
        txn_t e;
        @(negedge clk);
        if (rst_n && cyc && stb && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL bus_txn unexpected we=%0b addr=%h data=%h sel=%h", we, waddr, wdata, wsel);
            end else begin
                e = exp_q.pop_front();
                if (we !== e.we || waddr !== e.addr || wsel !== e.sel || (e.we && wdata !== e.data)) begin
                    fails++;
                    $display("FAIL bus_txn got we=%0b addr=%h data=%h sel=%h want we=%0b addr=%h data=%h sel=%h",
                             we, waddr, wdata, wsel, e.we, e.addr, e.data, e.sel);
                end
            end
        end
    endtask

    task automatic expect_txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.we = w; t.addr = a; t.data = d; t.sel = s;
        exp_q.push_back(t);
    endtask

    // Issue one PI1 op; reports cycles spent waiting for rdy and whether
    // every blocked cycle coincided with a full buffer.
    task automatic pi_op(input logic [1:0] o, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int waits, output bit blk_full);
        waits = 0;
        blk_full = 1;
        tick();
        while (!rdy && waits < 200) begin
            if (lvl != 3'd4) blk_full = 0;
            tick();
            waits++;
        end
        if (!rdy) begin
            checks++; fails++;
            $display("FAIL pi_op_rdy_timeout op=%0d addr=%h", o, a);
        end
        op = o; paddr = a; pdata = d; psel = s;
        @(posedge clk);
        #1;
        op = OP_NOOP;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        tick();
        while (!(rdy && !cyc && lvl == 0 && exp_q.size() == 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            checks++; fails++;
            $display("FAIL %s idle_timeout pending=%0d lvl=%0d", name, exp_q.size(), lvl);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) tick();
        checks++; if ({cyc, stb, we} !== 3'b000) begin fails++; $display("FAIL reset_bus got=%b want=000", {cyc, stb, we}); end
        checks++; if (rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy got=%b want=0", rdy); end
        checks++; if (lvl !== 3'd0) begin fails++; $display("FAIL reset_lvl got=%0d want=0", lvl); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", err_o); end
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        rst_n = 1'b1;
        tick();
        checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_release_rdy got=%b want=1", rdy); end
    endtask

    task automatic test_posted();
        int w, tot = 0, peak = 0;
        bit bf;
        lat = 3;
        for (int i = 0; i < 4; i++) expect_txn(1, 32'h40 + 32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) begin
            pi_op(OP_WR, 30'h10 + 30'(i), 32'h1000_0000 + 32'(i), 4'hF, w, bf);
            tot += w;
            if (int'(lvl) > peak) peak = int'(lvl);
        end
        checks++; if (tot !== 0) begin fails++; $display("FAIL posted_rdy_waits got=%0d want=0", tot); end
        checks++; if (peak < 3 || peak > 4) begin fails++; $display("FAIL posted_peak_lvl got=%0d want=3..4", peak); end
        wait_idle("posted");
        checks++; if (mem[16] !== 32'h1000_0000) begin fails++; $display("FAIL posted_mem0 got=%h want=10000000", mem[16]); end
        checks++; if (mem[19] !== 32'h1000_0003) begin fails++; $display("FAIL posted_mem3 got=%h want=10000003", mem[19]); end
    endtask

    task automatic test_buf_full();
        int w, tot = 0, peak = 0;
        bit bf, all_full = 1;
        lat = 1;
        stall_end = cyc_cnt + 12;
        for (int i = 0; i < 6; i++) expect_txn(1, 32'h80 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 6; i++) begin
            pi_op(OP_WR, 30'h20 + 30'(i), 32'hB000_0000 + 32'(i), 4'hF, w, bf);
            tot += w;
            if (!bf) all_full = 0;
            if (int'(lvl) > peak) peak = int'(lvl);
        end
        checks++; if (tot == 0) begin fails++; $display("FAIL full_rdy_never_low got=%0d want>0", tot); end
        checks++; if (!all_full) begin fails++; $display("FAIL full_blocked_not_full got=0 want=1"); end
        checks++; if (peak !== 4) begin fails++; $display("FAIL full_peak_lvl got=%0d want=4", peak); end
        wait_idle("buf_full");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[32 + i] !== 32'hB000_0000 + 32'(i)) begin
                fails++; $display("FAIL full_mem%0d got=%h want=%h", i, mem[32 + i], 32'hB000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_rd_order();
        int w, n = 0;
        bit bf, wr_acked = 0, early = 0;
        lat = 2;
        expect_txn(1, 32'h14, 32'hDEAD_BEEF, 4'hF);
        expect_txn(0, 32'h14, 32'h0, 4'hF);
        pi_op(OP_WR, 30'h5, 32'hDEAD_BEEF, 4'hF, w, bf);
        pi_op(OP_RD, 30'h5, 32'h0, 4'hF, w, bf);
        tick();
        while (!(rdy && !cyc && exp_q.size() == 0) && n < 200) begin
            if (cyc && we && ack) wr_acked = 1;
            if (cyc && !we && !wr_acked) early = 1;
            tick();
            n++;
        end
        checks++; if (early) begin fails++; $display("FAIL order_read_before_write_ack got=1 want=0"); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL order_rdata got=%h want=deadbeef", rdata); end
    endtask

    task automatic test_swap();
        int w, n = 0, rises = 0, falls = 0;
        bit bf, prev = 0;
        lat = 2;
        expect_txn(1, 32'h08, 32'hAAAA_5555, 4'hF);
        pi_op(OP_WR, 30'h2, 32'hAAAA_5555, 4'hF, w, bf);
        wait_idle("swap_pre");
        expect_txn(0, 32'h08, 32'h0, 4'hF);
        expect_txn(1, 32'h08, 32'h0000_1234, 4'hF);
        pi_op(OP_RW, 30'h2, 32'h0000_1234, 4'hF, w, bf);
        tick();
        while (!(rdy && !cyc && exp_q.size() == 0) && n < 200) begin
            if (cyc && !prev) rises++;
            if (!cyc && prev) falls++;
            prev = cyc;
            tick();
            n++;
        end
        if (!cyc && prev) falls++;
        checks++; if (rises !== 1 || falls !== 1) begin fails++; $display("FAIL swap_cyc_held rises=%0d falls=%0d want=1/1", rises, falls); end
        checks++; if (rdata !== 32'hAAAA_5555) begin fails++; $display("FAIL swap_rdata got=%h want=aaaa5555", rdata); end
        checks++; if (mem[2] !== 32'h0000_1234) begin fails++; $display("FAIL swap_mem got=%h want=00001234", mem[2]); end
    endtask

    task automatic test_zero_wait();
        int w, n = 0;
        bit bf;
        zw = 1;
        expect_txn(0, 32'h08, 32'h0, 4'hF);
        pi_op(OP_RD, 30'h2, 32'h0, 4'hF, w, bf);
        tick();
        while (!rdy && n < 50) begin
            n++;
            tick();
        end
        checks++; if (n !== 1) begin fails++; $display("FAIL zw_rdy_low_cycles got=%0d want=1", n); end
        checks++; if (rdata !== 32'h0000_1234) begin fails++; $display("FAIL zw_rdata got=%h want=00001234", rdata); end
        zw = 0;
    endtask

    task automatic test_byte_sel();
        int w;
        bit bf;
        logic [3:0]  sels [4];
        logic [31:0] addrs [4];
        sels[0] = 4'b0100; addrs[0] = 32'h0E;
        sels[1] = 4'b0000; addrs[1] = 32'h0C;
        sels[2] = 4'b1000; addrs[2] = 32'h0F;
        sels[3] = 4'b0110; addrs[3] = 32'h0D;
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            expect_txn(0, addrs[i], 32'h0, sels[i]);
            pi_op(OP_RD, 30'h3, 32'h0, sels[i], w, bf);
            wait_idle("byte_sel");
        end
    endtask

    task automatic test_timeout_err();
        int w, n = 0;
        bit bf;
        no_ack = 1;
        expect_txn(0, 32'h1C, 32'h0, 4'hF);
        pi_op(OP_RD, 30'h7, 32'h0, 4'hF, w, bf);
        tick();
        while (cyc && n < 100) begin
            n++;
            tick();
        end
        checks++; if (n !== 16) begin fails++; $display("FAIL tmo_cyc_len got=%0d want=16", n); end
        wait_idle("timeout");
        checks++; if (rdata !== 32'hFFFF_FFFF) begin fails++; $display("FAIL tmo_rdata got=%h want=ffffffff", rdata); end
        checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL tmo_err got=%b want=1", err_o); end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_clr got=%b want=0", err_o); end
        no_ack = 0;
        err_mode = 1;
        lat = 1;
        expect_txn(1, 32'h20, 32'h0000_0055, 4'hF);
        pi_op(OP_WR, 30'h8, 32'h0000_0055, 4'hF, w, bf);
        wait_idle("wr_err");
        checks++; if (lvl !== 3'd0) begin fails++; $display("FAIL wr_err_pop got=%0d want=0", lvl); end
        checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL wr_err_flag got=%b want=1", err_o); end
        err_mode = 0;
    endtask

    task automatic test_reset_mid();
        int w, n = 0;
        bit bf;
        lat = 1;
        stall_end = cyc_cnt + 60;
        expect_txn(1, 32'hC0, 32'h0, 4'hF);
        pi_op(OP_WR, 30'h30, 32'h0, 4'hF, w, bf);
        pi_op(OP_WR, 30'h31, 32'h1, 4'hF, w, bf);
        pi_op(OP_RW, 30'h9, 32'h2, 4'hF, w, bf);
        tick();
        while (!cyc && n < 20) begin
            n++;
            tick();
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({cyc, stb} !== 2'b00) begin fails++; $display("FAIL rst_mid_bus got=%b want=00", {cyc, stb}); end
        checks++; if (lvl !== 3'd0) begin fails++; $display("FAIL rst_mid_lvl got=%0d want=0", lvl); end
        checks++; if (rdy !== 1'b0) begin fails++; $display("FAIL rst_mid_rdy got=%b want=0", rdy); end
        exp_q.delete();
        stall_end = 0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL rst_mid_release_rdy got=%b want=1", rdy); end
        checks++; if (cyc !== 1'b0) begin fails++; $display("FAIL rst_mid_release_cyc got=%b want=0", cyc); end
    endtask

    initial begin
        test_reset();
        test_posted();
        test_buf_full();
        test_rd_order();
        test_swap();
        test_zero_wait();
        test_byte_sel();
        test_timeout_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
